rr_mux_sel_arbiter: RTL and testbench
=====================================

# rr_mux_sel_arbiter

Round-robin arbiter that generates the select for the 4:1 data mux (`mux_41`). Four sources request the shared output path. The block grants exactly one at a time and drives `sel[1:0]` straight into the mux select, plus a one-hot grant and a valid flag for the consumer. Each grant has a bounded tenure, and priority rotates so no source is starved.

## Interface
- `HOLD_CYCLES`, default 4: maximum consecutive cycles one grant lasts; legal range 1..15.
- `clk`  input  1  single clock; all state updates on its rising edge.
- `rst`  input  1  reset, asynchronous, active-high.
- `req`  input  4  request per source; bit i corresponds to mux input I[i].
- `done`  input  1  current owner finished; ends the active grant early.
- `sel`  output  2  binary index of the granted source; connects to mux `sel`.
- `grant`  output  4  one-hot grant; all zero when no grant is active.
- `valid`  output  1  high while a grant is active; mux output Y is meaningful only then.

## Operation
- Two states: IDLE and GRANT. All outputs are registered.
- Internal state:
  - `ptr[1:0]` is the round-robin start index.
  - `cnt[3:0]` is the tenure counter.
- IDLE:
  - If `req` is nonzero, pick the first set bit scanning `ptr`, `ptr+1`, `ptr+2`, `ptr+3` (mod 4). Call it w.
  - Next state GRANT; `sel` becomes w, `grant` becomes `1<<w`, `valid` becomes 1, `cnt` becomes 1.
  - If `req` is zero, stay in IDLE with outputs unchanged.
- GRANT ends at a clock edge when any of the following hold in that cycle:
  - `done`=1;
  - `req[sel]`=0;
  - `cnt`==`HOLD_CYCLES`.
- On end:
  - Next state IDLE; `valid` becomes 0, `grant` becomes 0.
  - `ptr` becomes `sel+1` mod 4, so 3 wraps to 0.
  - `sel` keeps its last value.
- Otherwise the block stays in GRANT and `cnt` increments.
- Exactly one IDLE cycle (valid=0) always separates consecutive grants, even when the same source is re-granted.
- `done` in IDLE is ignored.
- `req` changes on non-granted bits during GRANT have no effect until the next arbitration.
- Simultaneous end conditions (e.g. `done` together with expiry) cause a single termination with identical behaviour.
- Invariants:
  - `grant` is zero or one-hot.
  - When `valid`=1, `grant==1<<sel`.
  - `valid`==(`grant`!=0).

## Timing
- Reset values (asynchronous, immediate on `rst` rising, held while high): state IDLE, `sel`=2'b00, `grant`=4'b0000, `valid`=0, `ptr`=0, `cnt`=0.
- Reset mid-grant clears `grant` and `valid` without waiting for a clock edge. The first arbitration after release starts from source 0.
- Latency: request asserted in IDLE cycle N gives `valid`/`grant`/`sel` high in cycle N+1.
- Tenure with `req` held and no `done`: `valid` high for exactly `HOLD_CYCLES` cycles, then low for 1 cycle.
- `done` sampled high in grant cycle k means `valid` is low from cycle k+1.
- Dropping `req[sel]` in cycle k ends the grant the same way: `valid` low in cycle k+1.
- Throughput with all requests held: `HOLD_CYCLES` of every `HOLD_CYCLES+1` cycles valid.
- `HOLD_CYCLES`=1 gives alternating grant/idle cycles.

## Test plan
- Reset: assert `rst` mid-simulation with `req`=4'b1111 during a grant. Require immediate `sel`=00, `grant`=0000, `valid`=0; after release, the first grant goes to source 0.
- Single requester: `req`=4'b0100 held, `HOLD_CYCLES`=4. Require `sel`=10, `grant`=0100, and a `valid` pattern of 1,1,1,1,0 repeating.
- Rotation and wrap: `req`=4'b1111 held. Require grant order 0001, 0010, 0100, 1000, 0001, each of 4 cycles separated by 1 idle cycle.
- Early release:
  - `req`=4'b0011 held, `done` pulsed in the 2nd cycle of source 0's grant. Require `valid`=0 next cycle, then `sel`=01 granted.
  - Pulse `done` together with expiry. Require a single termination.
- Request drop: source 3 granted, deassert `req[3]` in its 1st grant cycle. Require `valid`=0 next cycle and `ptr` moving to 0 (the next grant goes to the lowest pending source ≥0).
- Integration with `mux_41`: `I`=4'b0100, `req`=4'b1111. Require mux `Y`=1 only while `grant`=0100 and `valid`=1, and `Y`=0 during the other grants.

Source files
------------

// File: rtl/rr_mux_sel_arbiter.sv
// Round-robin select generator for a 4:1 data mux.
// Each grant has a bounded tenure. Priority rotates past the last owner.
module rr_mux_sel_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       valid
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [3:0] HoldMax = 4'(HOLD_CYCLES);

    state_e     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] sel_q, sel_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;

    logic [1:0] win;
    logic       win_found;
    logic       end_grant;

    // The scan starts at ptr_q and wraps. The first pending source wins.
    always_comb begin
        logic [1:0] idx;
        win       = 2'd0;
        win_found = 1'b0;
        idx       = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    assign end_grant = done || !req[sel_q] || (cnt_q == HoldMax);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StGrant;
                    sel_d   = win;
                    grant_d = 4'b0001 << win;
                    valid_d = 1'b1;
                    cnt_d   = 4'd1;
                end
            end
            StGrant: begin
                if (end_grant) begin
                    // sel is held, so the mux keeps its last input while idle.
                    state_d = StIdle;
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    ptr_d   = sel_q + 2'd1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            ptr_q   <= 2'd0;
            cnt_q   <= 4'd0;
            sel_q   <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign sel   = sel_q;
    assign grant = grant_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_rr_mux_sel_arbiter.sv
// Bench for rr_mux_sel_arbiter: directed vector table, reset/rotation sequences,
// and random traffic against a cycle-level reference model.
module tb_rr_mux_sel_arbiter;

    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [1:0] sel;
    logic [3:0] grant;
    logic       valid;

    always #5 clk = ~clk;

    rr_mux_sel_arbiter #(.HOLD_CYCLES(H)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .done  (done),
        .sel   (sel),
        .grant (grant),
        .valid (valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: who owns the path, for how long, and where the next scan starts.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_ten;

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       v;
        logic [1:0] s;
        logic [3:0] g;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, want %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_ten   = 0;
    endtask

    task automatic model_step();
        bit found;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            found = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (!found && req[(m_ptr + k) % 4]) begin
                    found   = 1'b1;
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_ten  = 1;
            end
        end else if (done || !req[m_owner] || m_ten == H) begin
            m_busy = 1'b0;
            m_ptr  = (m_owner + 1) % 4;
        end else begin
            m_ten++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_step();
        check("model_valid", 32'(valid), 32'(m_busy));
        check("model_sel", 32'(sel), 32'(m_owner));
        check("model_grant", 32'(grant), m_busy ? (32'd1 << m_owner) : 32'd0);
    endtask

    task automatic add(input logic [3:0] r, input logic d, input logic v,
                       input logic [1:0] s, input logic [3:0] g);
        vec_t e;
        e.req  = r;
        e.done = d;
        e.v    = v;
        e.s    = s;
        e.g    = g;
        tbl.push_back(e);
    endtask

    logic [3:0] mux_i;
    logic [3:0] exp_g;

    initial begin
        // Single requester: 4 valid cycles, then 1 idle, repeating.
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c++) add(4'b0100, 1'b0, 1'b1, 2'd2, 4'b0100);
            add(4'b0100, 1'b0, 1'b0, 2'd2, 4'b0000);
        end
        // Early release by done in the 2nd grant cycle of source 0.
        add(4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001);
        add(4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001);
        add(4'b0011, 1'b1, 1'b0, 2'd0, 4'b0000);
        add(4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(4'b0011, 1'b0, 1'b1, 2'd1, 4'b0010);
        // done together with expiry: a single termination, then regrant.
        add(4'b0011, 1'b1, 1'b0, 2'd1, 4'b0000);
        add(4'b0011, 1'b0, 1'b1, 2'd0, 4'b0001);
        // Request drop on source 3 in its first grant cycle.
        add(4'b1000, 1'b0, 1'b0, 2'd0, 4'b0000);
        add(4'b1000, 1'b0, 1'b1, 2'd3, 4'b1000);
        add(4'b0110, 1'b0, 1'b0, 2'd3, 4'b0000);
        add(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(4'b0110, 1'b0, 1'b1, 2'd1, 4'b0010);
        add(4'b0000, 1'b0, 1'b0, 2'd1, 4'b0000);
        // done in idle is ignored.
        add(4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000);

        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_sel", 32'(sel), 32'd0);
        check("reset_grant", 32'(grant), 32'd0);
        check("reset_valid", 32'(valid), 32'd0);
        rst = 1'b0;

        foreach (tbl[i]) begin
            req  = tbl[i].req;
            done = tbl[i].done;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
            check($sformatf("tbl%0d_sel", i), 32'(sel), 32'(tbl[i].s));
            check($sformatf("tbl%0d_grant", i), 32'(grant), 32'(tbl[i].g));
        end

        // Reset in the middle of a grant clears outputs without a clock edge.
        req  = 4'b1111;
        done = 1'b0;
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_sel", 32'(sel), 32'd0);
        check("async_rst_grant", 32'(grant), 32'd0);
        check("async_rst_valid", 32'(valid), 32'd0);
        model_reset();
        step();
        rst = 1'b0;

        // Rotation and wrap with all requesting, plus the mux_41 integration check.
        mux_i = 4'b0100;
        for (int i = 0; i < 21; i++) begin
            step();
            exp_g = (i % 5 == 4) ? 4'b0000 : (4'b0001 << ((i / 5) % 4));
            check($sformatf("rot%0d_grant", i), 32'(grant), 32'(exp_g));
            check($sformatf("rot%0d_mux_y", i), 32'(mux_i[sel] & valid),
                  32'(exp_g == 4'b0100));
        end

        // Random traffic; requests are sticky so long tenures occur.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 9) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
